// File: rtl/sound_pkg.sv
// Shared definitions for the SOUND receive-side blocks: meter FSM states,
// the tolerance-window test and the common system clock rate.
package sound_pkg;

  localparam int SOUND_CLK_HZ = 50_000_000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  // Unsigned window test; a lower bound that would go negative clamps to zero.
  function automatic logic in_window(input logic [31:0] val,
                                     input logic [31:0] target,
                                     input logic [31:0] tol);
    logic [31:0] w_lo;
    logic [32:0] w_hi;
    w_lo = (target > tol) ? (target - tol) : 32'd0;
    w_hi = {1'b0, target} + {1'b0, tol};
    return (val >= w_lo) && ({1'b0, val} <= w_hi);
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronises an asynchronous level, optionally filters it and emits a
// registered one-cycle pulse per rising edge. Filter: TONE_PERIOD_METER_DEBOUNCE_EN.
module sig_sync_edge #(
  parameter int DEB_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_edge
);

  if (DEB_CYC < 1) begin : g_deb_chk
    $error("sig_sync_edge: DEB_CYC must be at least 1");
  end

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_edge;
  logic w_lvl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_sig;
      r_s2   <= r_s1;
      r_s3   <= w_lvl;
      r_edge <= w_lvl & ~r_s3;
    end
  end

`ifdef TONE_PERIOD_METER_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);

  logic          r_filt;
  logic [DW-1:0] r_deb;

  // Level follows s2 only after DEB_CYC consecutive disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_filt <= 1'b0;
      r_deb  <= '0;
    end else if (r_s2 != r_filt) begin
      if (r_deb == DW'(DEB_CYC - 1)) begin
        r_filt <= r_s2;
        r_deb  <= '0;
      end else begin
        r_deb <= r_deb + DW'(1);
      end
    end else begin
      r_deb <= '0;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_s2;
`endif

  assign o_edge = r_edge;

endmodule

// File: rtl/tone_period_meter.sv
// Measures iCLK cycles between rising edges of an external tone and reports
// lock when LOCK_N periods in a row fall inside tolerance. Option: TONE_PERIOD_METER_DEBOUNCE_EN.
module tone_period_meter
  import sound_pkg::*;
#(
  parameter int CLK_HZ    = SOUND_CLK_HZ,
  parameter int TARGET_HZ = 4,
  parameter int TOL_CYC   = 1000,
  parameter int LOCK_N    = 3,
  parameter int PERIOD_W  = 26,
  parameter int DEB_CYC   = 16
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSIG,
  output logic [PERIOD_W-1:0] oPERIOD,
  output logic                oVALID,
  output logic                oLOCK,
  output logic                oTIMEOUT
);

  localparam int TARGET_CYC = CLK_HZ / TARGET_HZ;
  localparam int LW         = $clog2(LOCK_N + 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_CYC = PERIOD_W'(2 * TARGET_CYC);
  localparam logic [LW-1:0]       LCNT_MAX    = LW'(LOCK_N);

  if (PERIOD_W > 31 || (64'(2 * TARGET_CYC) >= (64'd1 << PERIOD_W))) begin : g_w_chk
    $error("tone_period_meter: PERIOD_W too narrow for 2*TARGET_CYC");
  end
  if (LOCK_N < 1) begin : g_lock_chk
    $error("tone_period_meter: LOCK_N must be at least 1");
  end

  logic w_edge;

  sig_sync_edge #(
    .DEB_CYC (DEB_CYC)
  ) u_sync (
    .i_clk  (iCLK),
    .i_rst  (iRST),
    .i_sig  (iSIG),
    .o_edge (w_edge)
  );

  meter_state_t        r_state;
  meter_state_t        w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_tmo;
  logic                w_tmo_nxt;
  logic [LW-1:0]       r_lcnt;
  logic [LW-1:0]       w_lcnt_nxt;
  logic                r_lock;
  logic                w_lock_nxt;

  assign w_cnt_inc = r_cnt + PERIOD_W'(1);

  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // An edge arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_valid_nxt  = 1'b0;
    w_tmo_nxt    = 1'b0;
    w_lcnt_nxt   = r_lcnt;
    w_lock_nxt   = r_lock;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_edge) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_edge) begin
          w_period_nxt = w_cnt_inc;
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          if (in_window(32'(w_cnt_inc), 32'(TARGET_CYC), 32'(TOL_CYC))) begin
            if (r_lcnt != LCNT_MAX) w_lcnt_nxt = r_lcnt + LW'(1);
            w_lock_nxt = (w_lcnt_nxt == LCNT_MAX);
          end else begin
            w_lcnt_nxt = '0;
            w_lock_nxt = 1'b0;
          end
        end else if (w_cnt_inc == TIMEOUT_CYC) begin
          w_state_nxt = IDLE;
          w_tmo_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_lcnt_nxt  = '0;
          w_lock_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_tmo    <= 1'b0;
      r_lcnt   <= '0;
      r_lock   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_valid  <= w_valid_nxt;
      r_tmo    <= w_tmo_nxt;
      r_lcnt   <= w_lcnt_nxt;
      r_lock   <= w_lock_nxt;
    end
  end

  assign oPERIOD  = r_period;
  assign oVALID   = r_valid;
  assign oLOCK    = r_lock;
  assign oTIMEOUT = r_tmo;

endmodule

// File: tb/tb_tone_period_meter.sv
// Randomised scoreboard bench for tone_period_meter: a behavioural model of
// edge timing and lock rules predicts every strobe, period and lock level.
module tb_tone_period_meter;

  localparam int CLK_HZ    = 1000;
  localparam int TARGET_HZ = 4;
  localparam int TOL_CYC   = 5;
  localparam int LOCK_N    = 3;
  localparam int PERIOD_W  = 10;
  localparam int DEB_CYC   = 16;
  localparam int TGT       = CLK_HZ / TARGET_HZ;
`ifdef TONE_PERIOD_METER_DEBOUNCE_EN
  localparam int RUN = DEB_CYC;
  localparam int LAT = 3 + DEB_CYC;
`else
  localparam int RUN = 1;
  localparam int LAT = 3;
`endif

  logic                clk;
  logic                iRST;
  logic                iSIG;
  logic [PERIOD_W-1:0] oPERIOD;
  logic                oVALID;
  logic                oLOCK;
  logic                oTIMEOUT;

  tone_period_meter #(
    .CLK_HZ    (CLK_HZ),
    .TARGET_HZ (TARGET_HZ),
    .TOL_CYC   (TOL_CYC),
    .LOCK_N    (LOCK_N),
    .PERIOD_W  (PERIOD_W),
    .DEB_CYC   (DEB_CYC)
  ) dut (
    .iCLK     (clk),
    .iRST     (iRST),
    .iSIG     (iSIG),
    .oPERIOD  (oPERIOD),
    .oVALID   (oVALID),
    .oLOCK    (oLOCK),
    .oTIMEOUT (oTIMEOUT)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    bit tmo;
    int per;
  } ev_t;

  ev_t  exp_q[$];
  int   pend[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   run = 0;
  int   run_start = 0;
  int   last = 0;
  int   lc = 0;
  int   per = 0;
  int   exp_period = 0;
  bit   exp_lock = 1'b0;
  bit   armed = 1'b0;
  logic lvl = 1'b0;

  task automatic check(input string nm, input longint act, input longint expv);
    ncmp++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Reference model: a rising edge of the (optionally filtered) sampled level
  // shows up LAT clocks after the first high sample of the qualifying run.
  always @(posedge clk) begin
    cyc++;
    if (iRST) begin
      pend.delete();
      lvl = 1'b0; run = 0; armed = 1'b0; lc = 0;
      exp_period = 0; exp_lock = 1'b0;
    end else begin
      if (iSIG != lvl) begin
        if (run == 0) run_start = cyc;
        run++;
        if (run == RUN) begin
          lvl = iSIG;
          run = 0;
          if (lvl) pend.push_back(run_start + LAT);
        end
      end else begin
        run = 0;
      end
      if (pend.size() != 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        if (armed) begin
          per = cyc - last;
          if (per >= TGT - TOL_CYC && per <= TGT + TOL_CYC) begin
            if (lc < LOCK_N) lc++;
          end else begin
            lc = 0;
          end
          exp_lock   = (lc == LOCK_N);
          exp_period = per;
          exp_q.push_back('{tmo: 1'b0, per: per});
        end
        armed = 1'b1;
        last  = cyc;
      end else if (armed && (cyc - last) == 2 * TGT) begin
        armed    = 1'b0;
        lc       = 0;
        exp_lock = 1'b0;
        exp_q.push_back('{tmo: 1'b1, per: 0});
      end
    end
  end

  always @(negedge clk) begin
    if (oVALID === 1'b1 || oTIMEOUT === 1'b1 || exp_q.size() != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {oVALID, oTIMEOUT}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("valid", oVALID, !e.tmo);
        check("timeout", oTIMEOUT, e.tmo);
        if (!e.tmo) check("period", oPERIOD, e.per);
      end
    end
    if (cyc > 0) begin
      check("period_hold", oPERIOD, exp_period);
      check("lock", oLOCK, exp_lock);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic level(input logic v, input int n);
    iSIG = v;
    step(n);
  endtask

  task automatic tone(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      level(1'b1, p / 2);
      level(1'b0, p - p / 2);
    end
  endtask

  task automatic glitch_period();
    level(1'b1, 125);
    level(1'b0, 50);
    level(1'b1, 3);
    level(1'b0, 72);
  endtask

  initial begin
    iRST = 1'b1;
    iSIG = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      iSIG = ~iSIG;
      step(1);
      check("rst_period", oPERIOD, 0);
      check("rst_valid", oVALID, 0);
      check("rst_lock", oLOCK, 0);
      check("rst_timeout", oTIMEOUT, 0);
    end
    iSIG = 1'b0;
    iRST = 1'b0;
    step(3);

    tone(TGT, 6);
    tone(260, 1);
    tone(TGT, 4);
    level(1'b0, 600);
    tone(TGT, 2);

    level(1'b1, 100);
    iRST = 1'b1;
    step(1);
    iRST = 1'b0;
    level(1'b1, 25);
    level(1'b0, 125);
    tone(TGT, 5);

    for (int i = 0; i < 3; i++) glitch_period();
    tone(TGT, 4);

    tone(2 * TGT, 1);
    tone(2 * TGT - 1, 1);
    tone(2 * TGT + 1, 1);
    tone(TGT, 4);
    tone(2, 3);
    tone(TGT, 3);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        tone(TGT - 10 + $urandom_range(0, 20), 1);
      end else if (r == 6) begin
        glitch_period();
      end else if (r == 7) begin
        level(1'b1, $urandom_range(1, 40));
        level(1'b0, $urandom_range(1, 40));
      end else if (r == 8) begin
        tone($urandom_range(300, 520), 1);
      end else begin
        level(1'b1, $urandom_range(1, 200));
        iRST = 1'b1;
        step($urandom_range(1, 3));
        iRST = 1'b0;
        level(1'b0, $urandom_range(1, 200));
      end
    end

    level(1'b0, 2 * TGT + LAT + 20);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: got no end of stimulus, required finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
